// File: rtl/crtc_video_timing.sv
// CRTC raster timing: turns the live R0-R9/R12/R13 register values into
// character strobe, sync pulses, display enable and the ma/ra cell address.
module crtc_video_timing #(
  parameter int CHAR_DIV = 16
) (
  input  logic        clk16,
  input  logic        res,
  input  logic [7:0]  r0_h_total,
  input  logic [7:0]  r1_h_displayed,
  input  logic [7:0]  r2_h_sync_pos,
  input  logic [7:0]  r3_sync_width,
  input  logic [6:0]  r4_v_total,
  input  logic [4:0]  r5_v_adjust,
  input  logic [6:0]  r6_v_displayed,
  input  logic [6:0]  r7_v_sync_pos,
  input  logic [4:0]  r9_max_scan,
  input  logic [5:0]  r12_start_hi,
  input  logic [7:0]  r13_start_lo,
  output logic        char_en,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [13:0] ma,
  output logic [4:0]  ra
);

  localparam int DW = (CHAR_DIV > 2) ? $clog2(CHAR_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CHAR_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(CHAR_DIV - 2);

  logic [DW-1:0] div;
  logic [7:0]    h;
  logic [4:0]    ra_cnt;
  logic [6:0]    row;
  logic          adj;
  logic [13:0]   ma_row;
  logic [3:0]    hs_rem;
  logic [3:0]    vs_rem;

  logic          eol, last_scan, last_row, adj_last;
  logic          frame_first, hs_start, vs_start;
  logic [13:0]   ma_base;

  // A sync width field of 0 encodes 16; the 4-bit wrap of w-1 yields 15 for it.
  function automatic logic [3:0] width_m1(input logic [3:0] w);
    return w - 4'd1;
  endfunction

  always_comb begin
    eol         = (h >= r0_h_total);
    last_scan   = (ra_cnt >= r9_max_scan);
    last_row    = (row >= r4_v_total);
    adj_last    = ({1'b0, ra_cnt} + 6'd1) >= {1'b0, r5_v_adjust};
    frame_first = !adj && (row == 7'd0) && (ra_cnt == 5'd0) && (h == 8'd0);
    hs_start    = (h == r2_h_sync_pos);
    vs_start    = !adj && (row == r7_v_sync_pos) && (ra_cnt == 5'd0) && (h == 8'd0);
    ma_base     = frame_first ? {r12_start_hi, r13_start_lo} : ma_row;
  end

  always_ff @(posedge clk16) begin
    if (res) begin
      div     <= '0;
      char_en <= 1'b0;
      h       <= '0;
      ra_cnt  <= '0;
      row     <= '0;
      adj     <= 1'b0;
      ma_row  <= '0;
      hs_rem  <= '0;
      vs_rem  <= '0;
      hsync   <= 1'b0;
      vsync   <= 1'b0;
      de      <= 1'b0;
      ma      <= '0;
      ra      <= '0;
    end else begin
      div     <= (div == DIV_LAST) ? '0 : div + 1'b1;
      char_en <= (div == DIV_PRE);
      if (char_en) begin
        // Outputs describe the cell the counters currently point at.
        de <= (h < r1_h_displayed) && (row < r6_v_displayed) && !adj;
        ma <= ma_base + 14'(h);
        ra <= ra_cnt;
        if (hs_start) begin
          hsync  <= 1'b1;
          hs_rem <= width_m1(r3_sync_width[3:0]);
        end else if (hs_rem != 4'd0) begin
          hsync  <= 1'b1;
          hs_rem <= hs_rem - 4'd1;
        end else begin
          hsync  <= 1'b0;
        end
        // vsync is counted in whole lines, so it only changes at line start.
        if (h == 8'd0) begin
          if (vs_start) begin
            vsync  <= 1'b1;
            vs_rem <= width_m1(r3_sync_width[7:4]);
          end else if (vs_rem != 4'd0) begin
            vsync  <= 1'b1;
            vs_rem <= vs_rem - 4'd1;
          end else begin
            vsync  <= 1'b0;
          end
        end
        ma_row <= ma_base;
        if (eol) begin
          h <= '0;
          if (adj) begin
            if (adj_last) begin
              adj    <= 1'b0;
              ra_cnt <= '0;
              row    <= '0;
            end else begin
              ra_cnt <= ra_cnt + 5'd1;
            end
          end else if (last_scan) begin
            ra_cnt <= '0;
            ma_row <= ma_base + 14'(r1_h_displayed);
            if (last_row) begin
              row <= '0;
              adj <= (r5_v_adjust != 5'd0);
            end else begin
              row <= row + 7'd1;
            end
          end else begin
            ra_cnt <= ra_cnt + 5'd1;
          end
        end else begin
          h <= h + 8'd1;
        end
      end
    end
  end

endmodule

// File: doc/crtc_video_timing.md
# crtc_video_timing

Video timing generator that consumes the CRTC register file contents (R0–R9, R12, R13) and produces the raster timing for the PET display: horizontal/vertical sync, display enable, and the video RAM character address and scan-line row address for each character cell. It is the read side of the CRTC registers. The CPU and Pi write and read those registers elsewhere; this block turns their current values into counters and sync pulses that drive the video shifter and the VGA/composite output stage. Cursor (R10, R11, R14, R15) and light pen are out of scope.

## Interface
- CHAR_DIV, 16, clk16 cycles per character cell (1 MHz character rate for 40 columns).
- clk16  in  1  16 MHz system clock; all logic on rising edge.
- res  in  1  synchronous, active-high reset.
- r0_h_total  in  8  horizontal total minus 1, in characters.
- r1_h_displayed  in  8  characters displayed per line.
- r2_h_sync_pos  in  8  character index where hsync starts.
- r3_sync_width  in  8  [3:0] hsync width in characters, [7:4] vsync width in scan lines; 0 means 16.
- r4_v_total  in  7  vertical total minus 1, in character rows.
- r5_v_adjust  in  5  extra scan lines appended after the last row.
- r6_v_displayed  in  7  character rows displayed.
- r7_v_sync_pos  in  7  character row where vsync starts.
- r9_max_scan  in  5  scan lines per row minus 1.
- r12_start_hi  in  6  start address [13:8].
- r13_start_lo  in  8  start address [7:0].
- char_en  out  1  one-clk16 strobe marking each character cell.
- hsync  out  1  horizontal sync, active high.
- vsync  out  1  vertical sync, active high.
- de  out  1  display enable.
- ma  out  14  video RAM character address.
- ra  out  5  scan line within the character row.

## Operation
- Reset (res high at a clk16 edge): every counter is 0. The outputs char_en, hsync, vsync, de, ma and ra are all 0 after that edge. Reset mid-frame aborts the frame immediately. The first frame after reset starts at h=0, row=0, ra=0.
- Divider: counts 0..CHAR_DIV-1. char_en=1 during the clk16 cycle when the divider equals CHAR_DIV-1. All other state advances only on edges where char_en=1.
- Horizontal counter h: counts 0..R0, then wraps to 0. The wrap is end-of-line (EOL).
- Horizontal sync:
  - A width counter loads when h==R2 and holds hsync high for W_h characters (W_h = R3[3:0], or 16 when 0).
  - hsync may extend past EOL into the next line.
  - If R2>R0, hsync never asserts.
- Scan line counter ra: at EOL, ra increments. When ra==R9 at EOL, ra becomes 0 and row increments (end of row, EOR).
- Row and adjust:
  - After EOR of row==R4: if R5==0, the frame ends. Otherwise the block enters ADJUST state with ra restarting at 0.
  - In ADJUST, ra counts 0..R5-1 and the frame ends at the EOL where ra==R5-1.
  - States are ACTIVE and ADJUST. Frame end returns to ACTIVE with row=0, ra=0.
- Vertical sync:
  - When row==R7, ra==0 and h==0 in ACTIVE, vsync asserts for W_v scan lines (W_v = R3[7:4], or 16 when 0).
  - Lines are counted at EOL. vsync may span row, adjust and frame boundaries.
- Display enable: de = (h < R1) && (row < R6) && ACTIVE.
- Address generation:
  - At frame start, ma_row loads {R12,R13}.
  - At each EOR, ma_row += R1.
  - ma = ma_row + h.
  - All address arithmetic is 14-bit and wraps modulo 2^14.
- Register values are used live, except R12/R13, which are sampled only at frame start. A register change mid-frame takes effect at the next comparison that uses it.
- Degenerate settings:
  - R9=0: each scan line is a row.
  - R1>R0: de is high for the whole line.
  - R6>R4: de is high for all rows in ACTIVE.

## Timing
- All outputs are registered.
- hsync, vsync, de, ma and ra change only on the char_en edge. They are constant for the following CHAR_DIV clk16 cycles.
- ma/ra/de describe the current cell with zero added latency; the downstream fetch pipeline absorbs its own delay.
- Line period = (R0+1)·CHAR_DIV clk16 cycles.
- Frame period = ((R4+1)·(R9+1) + R5) lines.
- PET defaults (R0=0x31, R9=7, R4=0x28, R5=5): 800 clk16 per line, 333 lines per frame, 266400 clk16 per frame (≈60.06 Hz).

## Test plan
- Reset, then defaults: first char_en at clk16 cycle 15 after reset release. hsync rises at h=41 and stays high for 15 chars (240 clk16). The next rise is exactly 800 clk16 later.
- Full default frame: vsync first rises at line 264 (row 33, ra 0) and is high for 16 lines. Frame period is 266400 clk16. de is low in the final 5 adjust lines.
- Address: R12=0x10, R13=0x00 → ma=0x1000 at the first cell. At row 1, h=0, ma=0x1028. At row 1, h=39, ma=0x104F.
- Wrap: R12=0x3F, R13=0xF0, R1=40 → ma wraps from 0x3FFF to 0x0000 mid-row 0. Row 1 starts at 0x0018.
- R5=0: frame is 328 lines and ADJUST is never entered. R3=0x00: hsync is 16 chars and vsync is 16 lines.
- Assert res for 1 clk16 mid-line with vsync high: all outputs are 0 on the next edge. The next frame restarts at h=0, row 0, ma={R12,R13}.
